// File: rtl/vga_timing_ctrl.sv
// VGA sync timing sequencer: raw syncs, display enable and pixel coordinates.
// Optional frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_last, v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (en) state_d = RUN;
        end
        RUN, DRAIN: begin
          if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + CW'(1);
          end else begin
            h_d = h_q + CW'(1);
          end
          state_d = en ? RUN : DRAIN;
          // Only a draining frame may stop, and only on its last pixel
          if (state_q == DRAIN && !en && h_last && v_last)
            state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          h_d     = '0;
          v_d     = '0;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  assign de = busy
            & (int'(h_q) < H_ACTIVE)
            & (int'(v_q) < V_ACTIVE);

  assign hsync = busy
               & (int'(h_q) >= HS_BEG)
               & (int'(h_q) < HS_END);

  assign vsync = busy
               & (int'(v_q) >= VS_BEG)
               & (int'(v_q) < VS_END);

  assign x = busy ? h_q : '0;
  assign y = busy ? v_q : '0;

  assign line_start  = busy & ce & (h_q == '0);
  assign frame_start = line_start & (v_q == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt_q <= '0;
    else if (frame_start)
      frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA sync datapath. It generates raw horizontal and vertical sync pulses, display-enable, and pixel coordinates from free-running counters.
- Starts and stops cleanly on frame boundaries.
- Sync outputs are raw and active-high (1 = inside sync pulse). The downstream polarity stage applies the per-mode polarity before the pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel-clock enable; counters and state advance only when ce=1
- en  in  1  level run request
- hsync  out  1  raw horizontal sync, active-high
- vsync  out  1  raw vertical sync, active-high
- de  out  1  display enable (inside active area)
- x  out  CW  horizontal counter value
- y  out  CW  vertical counter value
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- line_start  out  1  one-cycle pulse at x=0 of each line
- busy  out  1  1 in RUN or DRAIN

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL likewise
- Reset (asynchronous, rst_n=0):
  - state=IDLE, h=0, v=0.
  - All outputs 0 immediately and held at 0 until rst_n is released.
- States:
  - IDLE: counters held at 0; hsync=vsync=de=busy=0.
    - en=1 & ce=1 -> RUN. Counters remain 0, so the first RUN cycle presents pixel (0,0).
  - RUN, on each ce=1:
    - h increments; at h=H_TOTAL-1, h wraps to 0 and v increments.
    - at v=V_TOTAL-1 with h=H_TOTAL-1, v wraps to 0.
    - en=0 (sampled on a ce=1 cycle) -> DRAIN; counters continue.
  - DRAIN: counters continue as in RUN.
    - en=1 & ce=1 -> RUN, with no counter disturbance.
    - at last pixel (h=H_TOTAL-1, v=V_TOTAL-1) with ce=1 and en=0 -> IDLE; counters load 0.
    - en=1 on the last pixel: stays running (-> RUN, wrap normally).
- Decodes, combinational from state and counter registers, all gated by busy:
  - de = (h<H_ACTIVE)&(v<V_ACTIVE)
  - hsync = (h>=H_ACTIVE+H_FP)&(h<H_ACTIVE+H_FP+H_SYNC)
  - vsync = (v>=V_ACTIVE+V_FP)&(v<V_ACTIVE+V_FP+V_SYNC)
  - x=h, y=v (both 0 in IDLE)
- Pulses:
  - line_start = busy & ce & (h==0).
  - frame_start = line_start & (v==0).
  - Each is asserted for exactly one clk per line/frame, even if ce is held high for many cycles.
- ce=0: all registers hold and pulses are 0; level outputs hold their values.
- Latency: the IDLE->RUN transition takes one ce-qualified cycle, and the first frame_start occurs on the first RUN ce cycle.
- Frames are never truncated by en. Only rst_n can abort mid-frame: all outputs drop to 0 asynchronously and the block restarts in IDLE.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt (16 bits).
  - Resets to 0.
  - Increments on every frame_start, wrapping 0xFFFF->0.
  - Holds its value across IDLE and is not cleared by en.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan (bench parameters: H 8/2/2/2, total 14; V 4/1/1/1, total 7; CW=4):
- Reset release, en=0, ce=1 for 20 cycles -> busy=0, x=y=0, all syncs/de/pulses 0.
- en=1 with ce=1 continuously -> frame_start at cycle 1 and then every 98 cycles; line_start every 14 cycles; de high for x 0..7 on y 0..3; hsync high for x=10,11; vsync high for all of y=5.
- ce toggled 1,0,1,0 while running -> x advances once per ce=1 cycle; frame_start period 196 clk; each pulse is one clk wide.
- en dropped at x=3,y=2 -> counting continues to (13,6), then IDLE with x=y=0, busy=0. Also: en re-raised at y=4 -> no gap, frame_start at the next (0,0).
- rst_n pulsed low at x=9,y=5 -> outputs 0 in the same cycle; after release with en=1 -> restart from (0,0) with frame_start.
- With VGA_TIMING_FRAME_CNT_EN, run 3 frames -> frame_cnt=3. Then drop en, idle, and re-enable -> frame_cnt=4 after the next frame_start.
